// File: rtl/l2switch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2switch_pkg
// Brief    : Frame layout shared by switch ports and EndDevices.
// Revision : 1.0
// ============================================================================
package l2switch_pkg;

    localparam int         c_sfd_w      = 4;
    localparam logic [3:0] c_sfd        = 4'b0101;
    // Slice the low ADDR_WIDTH bits to get the broadcast address of any port.
    localparam logic [31:0] c_bcast_addr = '1;

    typedef enum logic [0:0] {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } rx_state_t;

    function automatic int frame_width(input int addr_w, input int payload_w);
        return c_sfd_w + 2 * addr_w + payload_w;
    endfunction

    function automatic int sfd_lsb(input int depth);
        return depth - c_sfd_w;
    endfunction

    function automatic int dest_lsb(input int depth, input int addr_w);
        return depth - c_sfd_w - addr_w;
    endfunction

    function automatic int src_lsb(input int depth, input int addr_w);
        return depth - c_sfd_w - 2 * addr_w;
    endfunction

    function automatic int payload_width(input int depth, input int addr_w);
        return depth - c_sfd_w - 2 * addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, power-of-2 depth, head visible combinationally.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full  = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_rd;
    logic               w_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == c_full);
    assign count   = r_count;
    assign rd_data = empty ? '0 : r_mem[r_rptr];

    // A write into a full FIFO is legal only when the head leaves on the same edge.
    assign w_rd = rd_en & ~empty;
    assign w_wr = wr_en & (~full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_port_rx.sv
`default_nettype none
// ============================================================================
// Module   : switch_port_rx
// Brief    : Serial ingress port: SFD hunt, deserialise, frame FIFO, MAC learn.
// Revision : 1.0
// ============================================================================
module switch_port_rx #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int PORT_ID    = 0,
    parameter int PORT_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_bit,
    output logic [DEPTH-1:0]      out_frame,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  learn_valid,
    output logic [ADDR_WIDTH-1:0] learn_src,
    output logic [PORT_W-1:0]     learn_port,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    import l2switch_pkg::*;

    localparam int                 c_body_w  = DEPTH - c_sfd_w;
    localparam int                 c_cnt_w   = $clog2(c_body_w);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(c_body_w - 1);
    localparam int                 c_src_lsb = src_lsb(DEPTH, ADDR_WIDTH);

    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic [c_sfd_w-1:0]     r_win;
    logic [c_sfd_w-1:0]     w_win_nxt;
    logic [c_body_w-1:0]    r_body;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   w_last;
    logic [DEPTH-1:0]       w_frame;
    logic                   w_pop;
    logic                   w_room;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic                   w_unused_count;

    assign w_win_nxt = {r_win[c_sfd_w-2:0], rx_bit};
    assign w_last    = (r_state == ST_COLLECT) && (r_cnt == c_last);
    assign w_frame   = {c_sfd, r_body[c_body_w-2:0], rx_bit};

    assign w_pop     = out_valid & out_ready;
    assign w_room    = ~w_fifo_full | w_pop;
    assign w_push    = w_last & w_room;
    assign w_drop    = w_last & ~w_room;

    assign out_valid      = ~w_fifo_empty;
    assign learn_port     = PORT_W'(PORT_ID);
    assign w_unused_count = ^w_fifo_count;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT:    if (w_win_nxt == c_sfd) w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (w_last)             w_state_nxt = ST_HUNT;
            default:                            w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The window is held at all ones while collecting so payload bits can
    // never combine with the next frame's preamble into a false SFD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win  <= '1;
            r_body <= '1;
            r_cnt  <= '0;
        end else if (r_state == ST_HUNT) begin
            r_win <= w_win_nxt;
            r_cnt <= '0;
        end else begin
            r_win  <= '1;
            r_body <= {r_body[c_body_w-2:0], rx_bit};
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            learn_valid <= 1'b0;
            learn_src   <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            learn_valid <= w_last;
            overflow    <= w_drop;
            if (w_last) begin
                learn_src <= w_frame[c_src_lsb +: ADDR_WIDTH];
            end
            if (w_drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (w_frame),
        .rd_en   (w_pop),
        .rd_data (out_frame),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

endmodule
`default_nettype wire
